// File: rtl/timer_arbiter_pkg.sv
// Shared definitions for the UI timer arbiter: FSM state encoding, timer width,
// default prescaler divide and the flush-wait timeout.
package timer_arbiter_pkg;

   localparam int TIMER_W      = 4;
   localparam int DEF_TICK_DIV = 27_000_000;
   // Cycles FWAIT waits for the drained timer's expiry before giving up.
   localparam int FWAIT_MAX    = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ARM   = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4,
      ST_FLUSH = 3'd5,
      ST_FWAIT = 3'd6
   } state_t;

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first set request at or after
// the pointer, wrapping around. Reusable by any UI arbiter.
module timer_arbiter_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   // Scan from the pointer outward; the first hit wins and masks the rest.
   always_comb begin
      int j;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      j       = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(i_ptr) + k) % N;
         if (!o_any && i_req[j]) begin
            o_any      = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one 4-bit countdown timer among N_REQ requesters: round-robin grant,
// duration load, prescaled decrement tick, done pulse on expiry, and
// cancellation by draining the timer to zero.
module timer_arbiter
   import timer_arbiter_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int CW       = 25
) (
   input  logic                       clk,
   input  logic                       sys_reset_n,
   input  logic [N_REQ-1:0]           req,
   input  logic [TIMER_W*N_REQ-1:0]   req_value,
   output logic [N_REQ-1:0]           grant,
   output logic [N_REQ-1:0]           done,
   output logic                       busy,
   output logic                       tmr_start,
   output logic [TIMER_W-1:0]         tmr_value,
   output logic                       tmr_enable,
   input  logic                       tmr_expired,
   input  logic [TIMER_W-1:0]         tmr_countdown
);

   localparam int            IW        = $clog2(N_REQ);
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

   state_t              r_state;
   logic [CW-1:0]       r_pre;
   logic [IW-1:0]       r_ptr;
   logic [IW-1:0]       r_owner;
   logic [1:0]          r_fw_cnt;

   logic                w_tick;
   logic [N_REQ-1:0]    w_pick_grant;
   logic [IW-1:0]       w_pick_idx;
   logic                w_pick_any;
   logic [TIMER_W-1:0]  w_pick_val;
   logic                w_owner_req;
   logic [IW-1:0]       w_ptr_next;
   logic                w_unused_countdown;

   // The timer's live count is informational only.
   assign w_unused_countdown = ^tmr_countdown;

   timer_arbiter_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   assign w_pick_val  = req_value[TIMER_W*int'(w_pick_idx) +: TIMER_W];
   assign w_owner_req = req[r_owner];
   assign w_ptr_next  = (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + IW'(1);

   assign w_tick     = (r_pre == TICK_LAST);
   // Ticks outside RUN are dropped so the timer only counts while owned.
   assign tmr_enable = w_tick && (r_state == ST_RUN);
   assign busy       = (r_state != ST_IDLE);

   // Free-running prescaler, 0..TICK_DIV-1.
   always_ff @(posedge clk or negedge sys_reset_n) begin
      if (!sys_reset_n)        r_pre <= '0;
      else if (r_pre == TICK_LAST) r_pre <= '0;
      else                     r_pre <= r_pre + CW'(1);
   end

   // Arbitration FSM; all outputs except busy/tmr_enable are registered here.
   always_ff @(posedge clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_owner   <= '0;
         r_fw_cnt  <= '0;
         grant     <= '0;
         done      <= '0;
         tmr_start <= 1'b0;
         tmr_value <= '0;
      end else begin
         done      <= '0;
         tmr_start <= 1'b0;
         tmr_value <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_pick_any) begin
                  // Latch owner and duration now; later req_value edits are ignored.
                  r_owner   <= w_pick_idx;
                  grant     <= w_pick_grant;
                  tmr_start <= 1'b1;
                  tmr_value <= w_pick_val;
                  r_state   <= ST_LOAD;
               end
            end
            ST_LOAD: r_state <= ST_ARM;
            // One cycle to swallow a stale expiry left over from reset or load.
            ST_ARM:  r_state <= ST_RUN;
            ST_RUN: begin
               if (tmr_expired) begin
                  // Expiry beats a simultaneous cancel.
                  done    <= grant;
                  r_state <= ST_DONE;
               end else if (!w_owner_req) begin
                  // Cancel: reload zero so the timer drains and goes quiet.
                  tmr_start <= 1'b1;
                  tmr_value <= '0;
                  r_state   <= ST_FLUSH;
               end
            end
            ST_DONE: begin
               grant   <= '0;
               r_ptr   <= w_ptr_next;
               r_state <= ST_IDLE;
            end
            ST_FLUSH: begin
               r_fw_cnt <= '0;
               r_state  <= ST_FWAIT;
            end
            ST_FWAIT: begin
               // Leave on the drain expiry, or give up after FWAIT_MAX cycles.
               if (tmr_expired || (r_fw_cnt == 2'(FWAIT_MAX - 1))) begin
                  grant   <= '0;
                  r_ptr   <= w_ptr_next;
                  r_state <= ST_IDLE;
               end else begin
                  r_fw_cnt <= r_fw_cnt + 2'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one 4-bit countdown timer among N_REQ UI requesters, e.g. dial-tone timeout, ring timeout and menu timeout.
- Arbitrates round-robin, loads the granted requester's duration, and generates the timer's decrement tick from a prescaler.
- Returns a one-cycle done pulse to the owner on expiry. Supports cancellation.
- Sits between the UI FSMs and the timer instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TICK_DIV, 27_000_000, clk cycles per timer decrement (1 s at 27 MHz); minimum 2.
- CW, 25, prescaler counter width; must satisfy 2^CW >= TICK_DIV.

Ports:
- clk  in  1  system clock.
- sys_reset_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  level request per requester; held high until done or cancel.
- req_value  in  4*N_REQ  per-requester duration in ticks; slice i = bits [4i+3:4i].
- grant  out  N_REQ  one-hot current owner; zero when idle.
- done  out  N_REQ  one-hot, one-cycle expiry pulse to the owner.
- busy  out  1  timer in use (any state other than IDLE).
- tmr_start  out  1  one-cycle load strobe to the timer.
- tmr_value  out  4  duration presented with tmr_start.
- tmr_enable  out  1  decrement tick to the timer.
- tmr_expired  in  1  one-cycle pulse from the timer when its count reaches 0.
- tmr_countdown  in  4  timer count; informational only, unused by the FSM.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; prescaler 0.
- Prescaler: free-running, counts 0..TICK_DIV-1 and wraps. tick = (count == TICK_DIV-1).
- tmr_enable = tick && state==RUN; ticks in any other state are dropped.
- States:
  - IDLE: if any req, grant the first set bit at or after the pointer (wrapping); latch its index and req_value slice; go to LOAD. No req: stay.
  - LOAD: tmr_start=1, tmr_value=latched value; go to ARM.
  - ARM: tmr_expired ignored (masks the stale post-reset/load pulse); go to RUN.
  - RUN: tmr_expired=1 goes to DONE. Owner's req=0 (cancel) goes to FLUSH. Both in the same cycle: DONE wins.
  - DONE: done[owner]=1 for exactly this cycle; pointer = owner+1 mod N_REQ; go to IDLE.
  - FLUSH: tmr_start=1, tmr_value=0 (forces the timer to drain to 0); go to FWAIT.
  - FWAIT: wait for tmr_expired; no done pulse; pointer = owner+1; go to IDLE.
- grant is held from LOAD through DONE/FWAIT inclusive, and is 0 in IDLE.
- busy = (state != IDLE).
- Value 0 request: the timer self-drains. Expiry arrives without a tick; done still pulses.
- Latency from req rising in IDLE to tmr_start: 1 cycle. A new grant is possible on the cycle after DONE.
- Other requesters changing req while the timer is owned: ignored until IDLE. The owner's req_value changes after latch: ignored.
- req[owner] held high into the cycle after DONE: re-arbitrated fairly; the pointer has already moved past the owner.
- Reset asserted mid-operation: immediate return to reset values. The timer is reset by the same sys_reset_n (inverted externally).
- FWAIT timeout guard: if no tmr_expired within 4 cycles, go to IDLE anyway.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, ARM, RUN, DONE, FLUSH, FWAIT), TIMER_W=4, default TICK_DIV.
- One natural sub-module: rr_pick. Combinational round-robin priority picker taking (req, pointer) and returning (one-hot grant, index). It is reusable by other UI arbiters.
- Prescaler and FSM stay inline.

Test Plan:
- Reset, then req=4'b0001 with value 3, TICK_DIV=4:
  - tmr_start 1 cycle later with tmr_value=3.
  - grant=0001 and busy=1.
  - done[0] pulses after 3 ticks.
  - grant=0, busy=0 the next cycle.
- req=4'b1010 simultaneously from IDLE with pointer 0:
  - grant=0010 first.
  - After its done, grant=1000.
  - Pointer then 0, so a fresh req=0011 grants 0001.
- Cancel: owner 2 drops req mid-RUN:
  - FLUSH issues tmr_start with value 0.
  - No done pulse.
  - busy drops after the timer's expiry.
  - The next requester is served.
- Value 0 request: done pulses within 4 cycles of grant with no tick required. tmr_enable stays 0 outside RUN.
- Expiry coincident with owner req falling: done pulses and FLUSH is not entered.
- Assert sys_reset_n=0 during RUN: all outputs 0 asynchronously. After release, a pending req is re-granted from pointer 0.
